layer_serializer: RTL

- Consumes the parallel output of one fully-connected layer: the NUM_NEURONS-wide valid vector plus the packed result bus.
- Captures a complete result vector into a shadow bank.
- Replays it one word per cycle as a serial data/valid/address stream, in the form the next layer's serial input expects.
- Sits between consecutive nn_layer instances. Downstream flow control is a single ready_in.

---
 rtl/nn_defs_pkg.sv | 17 +
 rtl/relu_clamp.sv | 11 +
 rtl/layer_serializer.sv | 110 +++++++++++
 3 files changed

// File: rtl/nn_defs_pkg.sv
// Shared definitions for the fully-connected layer pipeline: address width
// default, serializer state encoding and an index-width helper.
package nn_defs;

   localparam int ADDR_WIDTH_DEF = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } ser_state_t;

   // Index width that never collapses to zero bits for single-word vectors.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/relu_clamp.sv
// Combinational ReLU on one two's-complement word: negatives become zero.
module relu_clamp #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] word,
   output logic [DATA_WIDTH-1:0] clamped
);

   assign clamped = word[DATA_WIDTH-1] ? '0 : word;

endmodule

// File: rtl/layer_serializer.sv
// Captures a full parallel result vector from one layer and replays it as a
// serial data/valid/address stream. Define LAYER_SER_RELU_EN to clamp at capture.
module layer_serializer
   import nn_defs::*;
#(
   parameter int NUM_NEURONS = 128,
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_NEURONS-1:0]            out_valids,
   input  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_in,
   input  logic                              ready_in,
   output logic [DATA_WIDTH-1:0]             data_out,
   output logic                              data_valid,
   output logic [ADDR_WIDTH-1:0]             local_addr,
   output logic                              busy,
   output logic                              done,
   output logic                              overrun
);

   localparam int IDX_W = clog2_min1(NUM_NEURONS);

   ser_state_t                             state, state_nx;
   logic [IDX_W-1:0]                       idx, idx_nx;
   logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] shadow;
   logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] word_in;
   logic                                   full, last, beat, capture, ovr_set;

   assign full = &out_valids;
   assign last = (idx == IDX_W'(NUM_NEURONS - 1));
   assign busy = (state == STREAM);

   for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_word
`ifdef LAYER_SER_RELU_EN
      relu_clamp #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
         .word    (layer_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .clamped (word_in[i])
      );
`else
      assign word_in[i] = layer_in[i*DATA_WIDTH +: DATA_WIDTH];
`endif
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      beat     = 1'b0;
      capture  = 1'b0;
      ovr_set  = 1'b0;
      case (state)
         IDLE: begin
            if (full) begin
               capture  = 1'b1;
               idx_nx   = '0;
               state_nx = STREAM;
            end
         end
         STREAM: begin
            if (ready_in) begin
               beat = 1'b1;
               if (last) begin
                  idx_nx = '0;
                  // A vector landing on the final beat chains straight into a new stream.
                  if (full) capture = 1'b1;
                  else      state_nx = IDLE;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end
            ovr_set = full && !(ready_in && last);
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && capture) shadow <= word_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         local_addr <= '0;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         data_valid <= beat;
         done       <= beat && last;
         if (beat) begin
            data_out   <= shadow[idx];
            local_addr <= ADDR_WIDTH'(idx);
         end
         if (ovr_set) overrun <= 1'b1;
      end
   end

endmodule
